// File: rtl/sr_stack_unit_pkg.sv
// Shared definitions for the schoolRISCV hardware stack: op codes and control FSM states.
package sr_stack_unit_pkg;

  typedef enum logic [2:0] {
    STK_NOP   = 3'd0,
    STK_PUSH  = 3'd1,
    STK_POP   = 3'd2,
    STK_PEEK  = 3'd3,
    STK_REPL  = 3'd4,
    STK_DUP   = 3'd5,
    STK_SWAP  = 3'd6,
    STK_CLEAR = 3'd7
  } stk_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWAP2 = 1'b1
  } stk_state_e;

endpackage

// File: rtl/sr_stack_mem.sv
// Stack storage: DEPTH x DATA_W register array, one synchronous write port, two async read ports.
module sr_stack_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [CNT_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CNT_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [CNT_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < CNT_W'(DEPTH))) begin
      mem_q[waddr[AW-1:0]] <= wdata;
    end
  end

  // Out-of-range addresses (count wrapped below zero) read as zero; callers never use them.
  always_comb begin
    rdata_a = (raddr_a < CNT_W'(DEPTH)) ? mem_q[raddr_a[AW-1:0]] : '0;
    rdata_b = (raddr_b < CNT_W'(DEPTH)) ? mem_q[raddr_b[AW-1:0]] : '0;
  end

endmodule

// File: rtl/sr_stack_unit.sv
// Parametrised hardware stack: push/pop/peek/replace/dup/swap/clear with sticky error flags.
module sr_stack_unit
  import sr_stack_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  amount,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  stk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  amount_q, amount_d, amount_m1, amount_m2;
  logic [DATA_W-1:0] data_o_q, data_o_d, tmp_q, tmp_d;
  logic              data_valid_q, data_valid_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              set_ovf, set_unf, is_empty, is_full;
  logic              we;
  logic [CNT_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata, top, second;

  assign amount_m1 = amount_q - CNT_W'(1);
  assign amount_m2 = amount_q - CNT_W'(2);
  assign is_empty  = (amount_q == '0);
  assign is_full   = (amount_q == CNT_W'(DEPTH));

  sr_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (amount_m1),
    .rdata_a (top),
    .raddr_b (amount_m2),
    .rdata_b (second)
  );

  always_comb begin
    state_d      = state_q;
    amount_d     = amount_q;
    data_o_d     = data_o_q;
    data_valid_d = 1'b0;
    tmp_d        = tmp_q;
    we           = 1'b0;
    waddr        = amount_q;
    wdata        = data_i;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            STK_PUSH: begin
              if (is_full) set_ovf = 1'b1;
              else begin
                we       = 1'b1;
                amount_d = amount_q + CNT_W'(1);
              end
            end
            STK_POP, STK_PEEK, STK_REPL: begin
              if (is_empty) set_unf = 1'b1;
              else begin
                data_o_d     = top;
                data_valid_d = 1'b1;
                if (op == STK_POP) amount_d = amount_m1;
                if (op == STK_REPL) begin
                  we    = 1'b1;
                  waddr = amount_m1;
                end
              end
            end
            STK_DUP: begin
              if (is_empty) set_unf = 1'b1;
              else if (is_full) set_ovf = 1'b1;
              else begin
                we       = 1'b1;
                wdata    = top;
                amount_d = amount_q + CNT_W'(1);
              end
            end
            // Single write port: move second-from-top up now, finish with the saved top in SWAP2.
            STK_SWAP: begin
              if (amount_q < CNT_W'(2)) set_unf = 1'b1;
              else begin
                we      = 1'b1;
                waddr   = amount_m1;
                wdata   = second;
                tmp_d   = top;
                state_d = ST_SWAP2;
              end
            end
            STK_CLEAR: amount_d = '0;
            default: ;
          endcase
        end
      end
      ST_SWAP2: begin
        we      = 1'b1;
        waddr   = amount_m2;
        wdata   = tmp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = (ovf_q & ~err_clr) | set_ovf;
    unf_d = (unf_q & ~err_clr) | set_unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      amount_q     <= '0;
      data_o_q     <= '0;
      data_valid_q <= 1'b0;
      tmp_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      amount_q     <= amount_d;
      data_o_q     <= data_o_d;
      data_valid_q <= data_valid_d;
      tmp_q        <= tmp_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign data_o     = data_o_q;
  assign data_valid = data_valid_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign amount     = amount_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_sr_stack_unit.sv
// Self-checking bench for sr_stack_unit (DEPTH=4): directed scenarios plus random ops vs a queue model.
module tb_sr_stack_unit;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, PEEK = 3'd3,
                         REPL = 3'd4, DUP = 3'd5, SWAP = 3'd6, CLR = 3'd7;

  logic              clk = 1'b0;
  logic              rst, op_valid, err_clr;
  logic [2:0]        op;
  logic [DATA_W-1:0] data_i, data_o;
  logic              ready, data_valid, empty, full, overflow, underflow;
  logic [CNT_W-1:0]  amount;

  int errors = 0;
  int checks = 0;

  // Reference model: the stack as a queue, back = top.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_dv, m_ovf, m_unf, m_busy;

  always #5 clk = ~clk;

  sr_stack_unit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .data_i     (data_i),
    .ready      (ready),
    .data_o     (data_o),
    .data_valid (data_valid),
    .empty      (empty),
    .full       (full),
    .amount     (amount),
    .overflow   (overflow),
    .underflow  (underflow),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ready", 32'(ready), 32'(!m_busy));
    check("amount", 32'(amount), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("data_o", data_o, m_dout);
  endtask

  task automatic model_step(input logic v, input logic [2:0] o, input logic [31:0] d,
                            input logic clr);
    logic so = 1'b0, su = 1'b0, nb = 1'b0;
    int n = q.size();
    logic [DATA_W-1:0] t;
    m_dv = 1'b0;
    if (v && !m_busy) begin
      case (o)
        PUSH: if (n == DEPTH) so = 1'b1; else q.push_back(d);
        POP:  if (n == 0) su = 1'b1; else begin m_dout = q.pop_back(); m_dv = 1'b1; end
        PEEK: if (n == 0) su = 1'b1; else begin m_dout = q[n-1]; m_dv = 1'b1; end
        REPL: if (n == 0) su = 1'b1; else begin m_dout = q[n-1]; q[n-1] = d; m_dv = 1'b1; end
        DUP:  if (n == 0) su = 1'b1; else if (n == DEPTH) so = 1'b1; else q.push_back(q[n-1]);
        SWAP: if (n < 2) su = 1'b1;
              else begin t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t; nb = 1'b1; end
        CLR:  q.delete();
        default: ;
      endcase
    end
    m_ovf  = (m_ovf && !clr) || so;
    m_unf  = (m_unf && !clr) || su;
    m_busy = nb;
  endtask

  task automatic apply(input logic v, input logic [2:0] o, input logic [31:0] d,
                       input logic clr);
    @(negedge clk);
    rst = 1'b0; op_valid = v; op = o; data_i = d; err_clr = clr;
    check("ready_pre", 32'(ready), 32'(!m_busy));
    @(posedge clk);
    model_step(v, o, d, clr);
    #1 check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; op = NOP; err_clr = 1'b0;
    @(posedge clk);
    q.delete();
    m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_busy = 1'b0;
    #1 check_all();
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; op = NOP; data_i = '0; err_clr = 1'b0;
    do_reset();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);

    // LIFO order
    apply(1, PUSH, 32'h11, 0); apply(1, PUSH, 32'h22, 0); apply(1, PUSH, 32'h33, 0);
    apply(1, POP, 0, 0); check("lifo_pop1", data_o, 32'h33);
    apply(1, POP, 0, 0); check("lifo_pop2", data_o, 32'h22);
    apply(1, POP, 0, 0); check("lifo_pop3", data_o, 32'h11);
    check("lifo_empty", 32'(empty), 32'd1);

    // Overflow at DEPTH=4
    for (int i = 1; i <= 5; i++) begin
      apply(1, PUSH, 32'(i), 0);
      if (i == 4) check("ovf_full4", 32'(full), 32'd1);
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    apply(1, POP, 0, 0); check("ovf_pop4", data_o, 32'd4);
    apply(0, NOP, 0, 1); check("ovf_clr", 32'(overflow), 32'd0);
    apply(1, CLR, 0, 0);

    // Underflow from empty
    apply(1, POP, 0, 0);  check("unf_pop_dv", 32'(data_valid), 32'd0);
    apply(1, PEEK, 0, 0); apply(1, SWAP, 0, 0);
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_ready", 32'(ready), 32'd1);
    apply(0, NOP, 0, 1);
    apply(1, PUSH, 32'hA, 0); apply(1, SWAP, 0, 0);
    check("unf_swap1", 32'(underflow), 32'd1);
    check("unf_amt1", 32'(amount), 32'd1);
    apply(1, CLR, 0, 1);

    // SWAP with a held PEEK request
    apply(1, PUSH, 32'hA, 0); apply(1, PUSH, 32'hB, 0);
    apply(1, SWAP, 0, 0); check("swap_busy", 32'(ready), 32'd0);
    apply(1, PEEK, 0, 0); check("swap_back", 32'(ready), 32'd1);
    apply(1, PEEK, 0, 0); check("swap_peek", data_o, 32'hA);
    apply(1, POP, 0, 0);  check("swap_pop1", data_o, 32'hA);
    apply(1, POP, 0, 0);  check("swap_pop2", data_o, 32'hB);

    // DUP / REPL
    apply(1, PUSH, 32'h7, 0); apply(1, DUP, 0, 0);
    apply(1, REPL, 32'h9, 0);
    check("repl_old", data_o, 32'h7); check("repl_amt", 32'(amount), 32'd2);
    apply(1, POP, 0, 0); check("dup_pop1", data_o, 32'h9);
    apply(1, POP, 0, 0); check("dup_pop2", data_o, 32'h7);

    // Reset during SWAP2, then CLEAR keeps flags
    apply(1, POP, 0, 0);
    for (int i = 0; i < 3; i++) apply(1, PUSH, 32'h40 + 32'(i), 0);
    apply(1, SWAP, 0, 0);
    do_reset();
    check("rstsw_amt", 32'(amount), 32'd0);
    check("rstsw_unf", 32'(underflow), 32'd0);
    for (int i = 0; i < 5; i++) apply(1, PUSH, 32'h50 + 32'(i), 0);
    apply(1, CLR, 0, 0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_ovf", 32'(overflow), 32'd1);

    // Random ops against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else begin
        int r = $urandom_range(0, 11);
        apply($urandom_range(0, 9) != 0, (r > 7) ? PUSH : 3'(r), $urandom,
              $urandom_range(0, 9) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
